// File: rtl/wc_pkg.sv
// Shared constants and types for the WC Winograd datapath: sample width,
// taps per tile and stride, used by the tile feeder, the core and the result side.
package wc_pkg;

    localparam int DW     = 10;
    localparam int TAPS   = 5;
    localparam int STRIDE = 2;
    localparam int TILE_W = TAPS * DW;
    localparam int CNT_W  = 16;

    typedef logic [DW-1:0]     sample_t;
    typedef logic [TILE_W-1:0] tile_t;

endpackage

// File: rtl/wc_tile_feeder_if.sv
// Sample-in / tile-out bus of the WC tile feeder.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer that raises valid keeps its payload (and valid)
// stable until that transfer; ready may depend combinationally on valid only
// on the consumer side (in_ready depends on out_valid/out_ready, never on
// in_valid). in_* is the sample stream into the feeder, out_* and D is the
// tile stream out of it; out_last and tile_cnt are side information.
interface wc_tile_feeder_if
    import wc_pkg::*;
();

    sample_t          in_data;
    logic             in_valid;
    logic             in_ready;
    tile_t            D;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [CNT_W-1:0] tile_cnt;

    // The feeder itself.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output D,
        output out_valid,
        input  out_ready,
        output out_last,
        output tile_cnt
    );

    // The environment: sample source plus WC core.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  D,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  tile_cnt
    );

endinterface

// File: rtl/wc_win_shift.sv
// TAPS-deep sample shift register. The newest sample enters at the top slot,
// the oldest sits in the lowest DW bits, matching the D bus layout.
module wc_win_shift
    import wc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_en,
    input  sample_t i_data,
    output tile_t   o_win
);

    tile_t r_win;

    // Shift every slot one step toward the oldest end when a sample is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win <= '0;
        end else if (i_en) begin
            r_win <= {i_data, r_win[TILE_W-1:DW]};
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/wc_tile_feeder.sv
// Streaming front-end for the WC Winograd core: turns a row-ordered sample
// stream into overlapping TAPS-sample windows taken every STRIDE samples and
// hands each window to the core as one D tile.
module wc_tile_feeder
    import wc_pkg::*;
#(
    parameter int ROW_LEN = 9
)(
    input  logic             clk,
    input  logic             rst,
    wc_tile_feeder_if.slave  bus
);

    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    // Row length must be odd so the last tile ends exactly on the row's last
    // sample, and long enough to hold at least one window.
    if (((ROW_LEN % 2) == 0) || (ROW_LEN < TAPS)) begin : g_bad_row_len
        $error("wc_tile_feeder: ROW_LEN must be odd and >= TAPS");
    end

    logic [COL_W-1:0] r_col;
    logic             r_out_valid;
    logic             r_out_last;
    logic [CNT_W-1:0] r_tile_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_handoff;
    logic             w_complete;
    logic             w_col_last;
    logic [31:0]      w_col_ext;
    tile_t            w_win;

    // Stall the input only while a tile is waiting on the core.
    assign w_in_ready = !(r_out_valid && !bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_handoff  = r_out_valid && bus.out_ready;

    // The accepted sample closes a window when it is at least TAPS-1 columns
    // into the row and on a stride boundary; col restarting at 0 each row
    // keeps stale samples of the previous row out of every valid tile.
    assign w_col_ext  = 32'(r_col);
    assign w_complete = (w_col_ext >= 32'(TAPS - 1)) &&
                        (((w_col_ext - 32'(TAPS - 1)) % 32'(STRIDE)) == 32'd0);
    assign w_col_last = (r_col == COL_W'(ROW_LEN - 1));

    wc_win_shift u_win_shift (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_accept),
        .i_data (bus.in_data),
        .o_win  (w_win)
    );

    // Column position of the next sample within its row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Tile valid/last: set by a completing accept, dropped after a handoff
    // that is not refilled in the same cycle, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept && w_complete) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_last;
        end else if (w_handoff) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Count of tiles taken by the core; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tile_cnt <= '0;
        end else if (w_handoff) begin
            r_tile_cnt <= r_tile_cnt + CNT_W'(1);
        end
    end

    // The window only shifts on accepts, which cannot happen while a tile is
    // stalled, so the registered window doubles as the stable D bus.
    assign bus.in_ready  = w_in_ready;
    assign bus.D         = w_win;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.tile_cnt  = r_tile_cnt;

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Directed bench for wc_tile_feeder: streamed rows, two-row stream,
// back-pressure, gapped input, asynchronous reset and saturating data.
module tb_wc_tile_feeder;
    import wc_pkg::*;

    localparam int ROW = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wc_tile_feeder_if bus ();

    wc_tile_feeder #(.ROW_LEN(ROW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks  = 0;
    int n_fail    = 0;
    int exp_tiles = 0;
    logic [TILE_W:0] exp_q[$];   // {last, tile}

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Tile whose newest sample has value `newest` and the four before it.
    function automatic tile_t seq_tile(input int newest);
        tile_t t;
        for (int i = 0; i < TAPS; i++) begin
            t[i*DW +: DW] = sample_t'(newest - (TAPS - 1) + i);
        end
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge: apply inputs, sample in_ready, then run
    // through the next rising edge to the following falling edge.
    task automatic drive(input logic v, input sample_t d, input logic ordy, output logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        rdy = bus.in_ready;
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic rdy;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_D",         64'(bus.D),         64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_last",  64'(bus.out_last),  64'd0);
        check_eq("rst_tile_cnt",  64'(bus.tile_cnt),  64'd0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, rdy);
        check_eq("rst_in_ready", 64'(rdy), 64'd1);
        exp_tiles = 0;
        exp_q.delete();
    endtask

    // Stream n samples (values 1..n, or all-ones when sat) from column 0,
    // out_ready held high; optionally a bubble cycle after every sample.
    task automatic run_stream(input int n, input bit gapped, input bit sat);
        logic rdy;
        logic [TILE_W:0] e;
        sample_t val;
        int p;
        bit cmp;
        for (int idx = 0; idx < n; idx++) begin
            val = sat ? 10'h3FF : sample_t'(idx + 1);
            p   = (idx % ROW) + 1;
            cmp = (p >= TAPS) && ((p - TAPS) % STRIDE == 0);
            if (cmp) begin
                exp_q.push_back({(p == ROW), (sat ? {TILE_W{1'b1}} : seq_tile(idx + 1))});
                exp_tiles++;
            end
            drive(1'b1, val, 1'b1, rdy);
            check_eq("stream_in_ready", 64'(rdy), 64'd1);
            check_eq("stream_out_valid", 64'(bus.out_valid), 64'(cmp));
            if (bus.out_valid) begin
                check_eq("tile_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("tile_D",    64'(bus.D),        64'(e[TILE_W-1:0]));
                    check_eq("tile_last", 64'(bus.out_last), 64'(e[TILE_W]));
                end
            end
            if (gapped) begin
                drive(1'b0, '0, 1'b1, rdy);
                check_eq("gap_out_valid", 64'(bus.out_valid), 64'd0);
            end
        end
        drive(1'b0, '0, 1'b1, rdy);
        check_eq("stream_end_valid",    64'(bus.out_valid), 64'd0);
        check_eq("stream_tile_cnt",     64'(bus.tile_cnt),  64'(exp_tiles));
        check_eq("stream_queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic rdy;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // One row of samples 1..9: tiles {5..1}, {7..3}, {9..5}, last on the third.
        do_reset();
        run_stream(ROW, 1'b0, 1'b0);

        // Two rows back to back: row-2 first tile {14..10}, 6 tiles total.
        do_reset();
        run_stream(2 * ROW, 1'b0, 1'b0);

        // Back-pressure after the first tile.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, sample_t'(k), 1'b1, rdy);
        end
        drive(1'b1, sample_t'(5), 1'b0, rdy);
        check_eq("bp_first_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bp_first_D",     64'(bus.D),         64'(seq_tile(5)));
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, sample_t'(6), 1'b0, rdy);
            check_eq("bp_in_ready", 64'(rdy),           64'd0);
            check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("bp_hold_D",   64'(bus.D),         64'(seq_tile(5)));
            check_eq("bp_hold_last", 64'(bus.out_last), 64'd0);
        end
        drive(1'b1, sample_t'(6), 1'b1, rdy);
        check_eq("bp_release_ready", 64'(rdy),           64'd1);
        check_eq("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check_eq("bp_cnt_after_first", 64'(bus.tile_cnt), 64'd1);
        drive(1'b1, sample_t'(7), 1'b1, rdy);
        check_eq("bp_second_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bp_second_D",     64'(bus.D),         64'(seq_tile(7)));
        check_eq("bp_second_last",  64'(bus.out_last),  64'd0);
        drive(1'b0, '0, 1'b1, rdy);
        check_eq("bp_tile_cnt", 64'(bus.tile_cnt), 64'd2);

        // Gapped input: same tiles, each valid exactly one cycle after its accept.
        do_reset();
        run_stream(ROW, 1'b1, 1'b0);

        // Asynchronous reset mid-row, with tile_cnt already non-zero.
        do_reset();
        run_stream(ROW, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, sample_t'(k), 1'b1, rdy);
        end
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_D",         64'(bus.D),         64'd0);
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_tile_cnt",  64'(bus.tile_cnt),  64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_tiles = 0;
        exp_q.delete();
        run_stream(TAPS, 1'b0, 1'b0);

        // Saturating data: every tile all ones across 50 bits.
        do_reset();
        run_stream(ROW, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Streaming front-end that drives the 5-sample, 10-bit-per-sample D interface of the WC Winograd core (50-bit D bus, 2 outputs per tile).
- Accepts one 10-bit sample per cycle over a valid/ready handshake.
- Builds overlapping 5-sample windows with stride 2 along each row and presents each window as one tile on D with a valid/ready handshake.
- Sits between the sample source and the WC core; it is the transmitting end of the D tile interface.

Parameters:
- DW, 10, sample width in bits.
- TAPS, 5, samples per tile (window length).
- STRIDE, 2, new samples per tile after the first; equals outputs per tile.
- ROW_LEN, 9, samples per row. Must be odd and >= TAPS; elaboration-time check.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DW  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder accepts a sample this cycle.
- D  out  TAPS*DW  tile to WC core; D[DW-1:0] = oldest sample, D[TAPS*DW-1:(TAPS-1)*DW] = newest.
- out_valid  out  1  D holds a complete tile.
- out_ready  in  1  WC core consumes the tile this cycle.
- out_last  out  1  current tile is the last tile of its row (qualified by out_valid).
- tile_cnt  out  16  tiles handed off since reset; wraps at 2^16.

Behaviour:
- Reset (rst=0, asynchronous):
  - window registers, D = 0
  - out_valid = 0, out_last = 0
  - column counter col = 0, tile_cnt = 0
  - in_ready = 1 one cycle after deassertion
  - Reset mid-row discards the partial window and any pending tile.
- Accept rule: accept = in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready), combinational. No input bubble when the core is ready.
- On accept:
  - window shifts toward the oldest end: w[i] <= w[i+1] for i = 0..TAPS-2, and w[TAPS-1] <= in_data.
  - col increments; it wraps to 0 after ROW_LEN-1.
- Tile-complete condition, evaluated on the accepted sample's col before increment: col >= TAPS-1 and (col-(TAPS-1)) mod STRIDE == 0.
- Latency and flags:
  - out_valid rises the cycle after the completing sample is accepted.
  - D equals the updated window in that same cycle.
  - out_last = 1 when the completing col == ROW_LEN-1.
  - Tiles per row = 1 + (ROW_LEN-TAPS)/STRIDE, which is 3 for the defaults.
- Hold: while out_valid && !out_ready, D, out_valid and out_last are stable and in_ready = 0.
- Handoff (out_valid && out_ready):
  - tile_cnt increments.
  - If the same cycle accepts a completing sample, out_valid stays 1 and D updates (back-to-back tiles).
  - Otherwise out_valid clears next cycle.
- Row boundary: the first tile of a new row uses only new-row samples. Stale window contents from the previous row never appear in a valid tile because col restarts at 0.
- in_valid low: no state change other than handoff.
- No combinational path from in_data to D; D is registered.

Decomposition:
- Shared package wc_pkg holds:
  - DW, TAPS, STRIDE constants (shared with WC core and the result side)
  - a sample_t typedef (logic [DW-1:0])
  - a tile_t typedef (logic [TAPS*DW-1:0])
- One natural sub-module: wc_win_shift, the TAPS-deep sample shift register with an enable. Column counter and handshake control stay in wc_tile_feeder.

Test Plan:
- Reset, then stream samples 1..9 with in_valid=1 and out_ready=1 constantly:
  - tiles D = {5,4,3,2,1}, {7,6,5,4,3}, {9,8,7,6,5} (newest first), each 1 cycle after samples 5, 7 and 9
  - out_last = 1 only on the third tile
  - tile_cnt = 3
  - in_ready never drops.
- Two rows back-to-back (samples 1..18): the first tile of row 2 is {14,13,12,11,10}; no tile mixes rows; tile_cnt = 6.
- Back-pressure: hold out_ready = 0 after the first tile:
  - D stays {5,4,3,2,1} and in_ready = 0 for 10 cycles; samples 6 and 7 are not accepted.
  - After out_ready returns to 1, the next tile is {7,6,5,4,3}.
- Gapped input: in_valid toggles every other cycle. Tiles are unchanged from scenario 1; each out_valid rises exactly 1 cycle after the completing accept.
- Reset asserted asynchronously after sample 3 of a row:
  - D = 0, out_valid = 0 and tile_cnt = 0 immediately, with no clock edge.
  - Samples 1..5 after release produce {5,4,3,2,1}.
- Saturating data: feed 10'h3FF for all 9 samples; every tile is D = 50'h3_FFFF_FFFF_FFFF; no width truncation or sign issues.
